pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Consumer of the 3-bit next-PC select code produced by the control decode stage.
//   Holds the architectural PC register of the single-cycle MIPS core.
//   Computes the sequential, jump, branch and register targets, then commits the selected target each cycle.
//   Adds a RUN/HALT guard, a redirect statistics counter and an illegal-select flag; feeds the IM address and the link (pc+4) path.
// PARAMETERS
//   PC_RESET   32'h0000_3000  PC value loaded on reset; lowest legal fetch address
//   PC_LIMIT   32'h0000_6FFC  highest legal fetch address (inclusive)
//   CNT_W      32             width of redirect_cnt
// PORTS
//   clk           in   1      system clock, all state on rising edge
//   reset         in   1      synchronous, active-high reset
//   stall         in   1      1 = hold PC/state/counters this cycle
//   npc_op        in   3      000 seq, 001 j index, 010 beq offset, 011 register, 1xx illegal
//   imm26         in   26     instr[25:0]; imm16 = imm26[15:0]
//   cmp_eq        in   1      branch compare result (rs==rt)
//   rs_val        in   32     register-jump target
//   pc            out  32     current PC (registered)
//   pc_plus4      out  32     pc + 4, combinational, link value
//   halted        out  1      1 while FSM in HALT
//   addr_err      out  1      sticky: halt caused by bad target (range/alignment)
//   illegal_op    out  1      registered one-cycle pulse: npc_op was 1xx
//   redirect_cnt  out  CNT_W  count of committed non-sequential updates
// BEHAVIOUR
//   Reset values: pc=PC_RESET, halted=0, addr_err=0, illegal_op=0, redirect_cnt=0, FSM=RUN.
//   Reset has priority over stall, HALT and everything else.
//   Targets, all 32-bit with modulo-2^32 wrap:
//   - seq = pc+4.
//   - j   = {pc_plus4[31:28], imm26, 2'b00}.
//   - br  = pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}); taken only if cmp_eq=1, else seq.
//   - jr  = rs_val.
//   - 1xx selects seq and raises illegal_op next cycle.
//   FSM RUN: each non-stalled edge, the next target is validated.
//   - If PC_RESET <= target <= PC_LIMIT (and the alignment check passes), pc <= target.
//   - Otherwise pc holds, FSM -> HALT, addr_err <= 1.
//   FSM HALT: pc, counters and flags frozen; halted=1. Only reset exits HALT.
//   Latency: a target is visible on pc one edge after npc_op is presented; pc_plus4 follows pc the same cycle.
//   redirect_cnt: +1 on a committed j, jr or taken beq; wraps at 2^CNT_W.
//   - Not counted: stalled cycles, untaken beq, or a redirect that faults into HALT.
//   illegal_op: set for exactly one cycle after a non-stalled RUN cycle with npc_op[2]=1, cleared otherwise.
//   stall=1: no state changes at all; illegal_op deasserts.
//   Reset mid-branch or mid-stall: all pending selection is discarded.
// CONFIGURATION
//   PC_ALIGN_CHECK_EN defined: a target with target[1:0]!=0 is a fault (HALT, addr_err=1).
//   PC_ALIGN_CHECK_EN undefined: target[1:0] is forced to 2'b00 before the range check; no alignment fault exists.
// STRUCTURE
//   npc_pkg: NPC_SEQ=3'b000, NPC_J=3'b001, NPC_BR=3'b010, NPC_JR=3'b011;
//     FSM encoding S_RUN=1'b0, S_HALT=1'b1; PC_RESET/PC_LIMIT defaults.
//   Sub-module npc_target_calc: purely combinational target mux + range/alignment check.
//   pc_sequencer keeps the registers, FSM and counter.
// TESTING
//   1 reset 2 cycles -> pc=0x3000, halted=0, redirect_cnt=0; npc_op=000 x3 -> pc 0x3004,0x3008,0x300C.
//   2 pc=0x3008, npc_op=010, imm16=0xFFFF, cmp_eq=1 -> pc=0x3008, cnt+1;
//     same with cmp_eq=0 -> pc=0x300C, cnt unchanged.
//   3 npc_op=001, imm26=0x0000C10 -> pc=0x3040, cnt+1;
//     npc_op=011, rs_val=0x3100 -> pc=0x3100, cnt+1.
//   4 npc_op=011, rs_val=0x7000 -> pc holds, halted=1, addr_err=1;
//     further ops/stall ignored until reset -> pc=0x3000, halted=0, addr_err=0.
//   5 rs_val=0x3102, npc_op=011: with PC_ALIGN_CHECK_EN -> HALT, addr_err=1;
//     without -> pc=0x3100.
//   6 stall=1 with npc_op=001 -> pc, cnt unchanged;
//     npc_op=100 unstalled -> pc+4, illegal_op=1 for one cycle.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: next-PC select codes, FSM encoding and default PC bounds
package npc_pkg;
  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_J = 3'b001;
  localparam logic [2:0] NPC_BR = 3'b010;
  localparam logic [2:0] NPC_JR = 3'b011;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6FFC;
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;
endpackage

// File: rtl/npc_target_calc.sv
// npc_target_calc: combinational next-PC target mux with range/alignment check; ports pc,npc_op,imm26,cmp_eq,rs_val -> pc_plus4,target,redirect,ok; PC_ALIGN_CHECK_EN makes misaligned targets faults
module npc_target_calc
  import npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [25:0] imm26,
  input  logic        cmp_eq,
  input  logic [31:0] rs_val,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        redirect,
  output logic        ok
);
  logic [31:0] j_t, br_t, raw;
  logic        in_range;
  assign pc_plus4 = pc + 32'd4;
  assign j_t = {pc_plus4[31:28], imm26, 2'b00};
  assign br_t = pc_plus4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
  always_comb begin
    raw = pc_plus4;
    redirect = 1'b0;
    if (!npc_op[2]) begin
      raw = npc_op == NPC_J ? j_t :
            npc_op == NPC_BR ? (cmp_eq ? br_t : pc_plus4) :
            npc_op == NPC_JR ? rs_val : pc_plus4;
      redirect = npc_op == NPC_J || npc_op == NPC_JR || (npc_op == NPC_BR && cmp_eq);
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  assign target = raw;
  assign in_range = raw >= PC_RESET && raw <= PC_LIMIT;
  assign ok = in_range && raw[1:0] == 2'b00;
`else
  assign target = {raw[31:2], 2'b00};
  assign in_range = target >= PC_RESET && target <= PC_LIMIT;
  assign ok = in_range;
`endif
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with RUN/HALT guard, redirect counter and illegal-select pulse; ports clk,reset,stall,npc_op,imm26,cmp_eq,rs_val -> pc,pc_plus4,halted,addr_err,illegal_op,redirect_cnt; PC_ALIGN_CHECK_EN enables alignment faults
module pc_sequencer
  import npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic [25:0]      imm26,
  input  logic             cmp_eq,
  input  logic [31:0]      rs_val,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             addr_err,
  output logic             illegal_op,
  output logic [CNT_W-1:0] redirect_cnt
);
  state_t             state, state_n;
  logic [31:0]        target, pc_n;
  logic               redirect, ok, err_n, ill_n;
  logic [CNT_W-1:0]   cnt_n;
  npc_target_calc #(.PC_RESET(PC_RESET), .PC_LIMIT(PC_LIMIT)) u_calc (
    .pc(pc), .npc_op(npc_op), .imm26(imm26), .cmp_eq(cmp_eq), .rs_val(rs_val),
    .pc_plus4(pc_plus4), .target(target), .redirect(redirect), .ok(ok)
  );
  assign halted = state == S_HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      pc <= PC_RESET;
      addr_err <= 1'b0;
      illegal_op <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      addr_err <= err_n;
      illegal_op <= ill_n;
      redirect_cnt <= cnt_n;
    end
  end
  // A faulting target leaves pc and the counter untouched and parks the FSM in HALT.
  always_comb begin
    state_n = state;
    pc_n = pc;
    err_n = addr_err;
    ill_n = 1'b0;
    cnt_n = redirect_cnt;
    if (!stall && state == S_RUN) begin
      ill_n = npc_op[2];
      if (ok) begin
        pc_n = target;
        cnt_n = redirect_cnt + CNT_W'(redirect);
      end else begin
        state_n = S_HALT;
        err_n = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, cmp_eq;
  logic [2:0]  npc_op;
  logic [25:0] imm26;
  logic [31:0] rs_val, pc, pc_plus4, redirect_cnt;
  logic        halted, addr_err, illegal_op;
  int          total = 0, passed = 0;

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic [2:0]  op;
    logic [25:0] imm;
    logic        eq;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic        e_h;
    logic        e_err;
    logic        e_ill;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] ALN_PC = 32'h3108, ALN_CNT = 32'd4;
  localparam logic        ALN_H = 1'b1;
`else
  localparam logic [31:0] ALN_PC = 32'h3100, ALN_CNT = 32'd5;
  localparam logic        ALN_H = 1'b0;
`endif

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .imm26(imm26),
    .cmp_eq(cmp_eq), .rs_val(rs_val), .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
    .addr_err(addr_err), .illegal_op(illegal_op), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic stl, input logic [2:0] op, input logic [25:0] imm,
                     input logic eq, input logic [31:0] rs, input logic [31:0] e_pc, input logic e_h,
                     input logic e_err, input logic e_ill, input logic [31:0] e_cnt);
    vecs.push_back({rst, stl, op, imm, eq, rs, e_pc, e_h, e_err, e_ill, e_cnt});
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; stall = v.stl; npc_op = v.op; imm26 = v.imm; cmp_eq = v.eq; rs_val = v.rs;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d pc", idx), pc, v.e_pc);
    chk($sformatf("v%0d pc_plus4", idx), pc_plus4, v.e_pc + 32'd4);
    chk($sformatf("v%0d halted", idx), {31'b0, halted}, {31'b0, v.e_h});
    chk($sformatf("v%0d addr_err", idx), {31'b0, addr_err}, {31'b0, v.e_err});
    chk($sformatf("v%0d illegal_op", idx), {31'b0, illegal_op}, {31'b0, v.e_ill});
    chk($sformatf("v%0d redirect_cnt", idx), redirect_cnt, v.e_cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_op = 3'b000; imm26 = '0; cmp_eq = 1'b0; rs_val = '0;
    //   rst  stl  op      imm26          eq    rs             pc         h     err   ill   cnt
    add(1'b1, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3000, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b1, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3000, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3004, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3008, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h300C, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b011, 26'h0,        1'b0, 32'h3008,   32'h3008, 1'b0, 1'b0, 1'b0, 32'd1);
    add(1'b0, 1'b0, 3'b010, 26'h000FFFF,  1'b1, 32'h0,      32'h3008, 1'b0, 1'b0, 1'b0, 32'd2);
    add(1'b0, 1'b0, 3'b010, 26'h000FFFF,  1'b0, 32'h0,      32'h300C, 1'b0, 1'b0, 1'b0, 32'd2);
    add(1'b0, 1'b0, 3'b001, 26'h0000C10,  1'b0, 32'h0,      32'h3040, 1'b0, 1'b0, 1'b0, 32'd3);
    add(1'b0, 1'b0, 3'b011, 26'h0,        1'b0, 32'h3100,   32'h3100, 1'b0, 1'b0, 1'b0, 32'd4);
    add(1'b0, 1'b1, 3'b001, 26'h0000C10,  1'b0, 32'h0,      32'h3100, 1'b0, 1'b0, 1'b0, 32'd4);
    add(1'b0, 1'b0, 3'b100, 26'h0,        1'b0, 32'h0,      32'h3104, 1'b0, 1'b0, 1'b1, 32'd4);
    add(1'b0, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3108, 1'b0, 1'b0, 1'b0, 32'd4);
    add(1'b0, 1'b1, 3'b111, 26'h0,        1'b0, 32'h0,      32'h3108, 1'b0, 1'b0, 1'b0, 32'd4);
    add(1'b0, 1'b0, 3'b011, 26'h0,        1'b0, 32'h3102,   ALN_PC,   ALN_H, ALN_H, 1'b0, ALN_CNT);
    add(1'b1, 1'b1, 3'b011, 26'h0,        1'b0, 32'h3100,   32'h3000, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b010, 26'h0000010,  1'b1, 32'h0,      32'h3044, 1'b0, 1'b0, 1'b0, 32'd1);
    add(1'b0, 1'b0, 3'b011, 26'h0,        1'b0, 32'h7000,   32'h3044, 1'b1, 1'b1, 1'b0, 32'd1);
    add(1'b0, 1'b0, 3'b001, 26'h0000C10,  1'b0, 32'h0,      32'h3044, 1'b1, 1'b1, 1'b0, 32'd1);
    add(1'b0, 1'b0, 3'b100, 26'h0,        1'b0, 32'h0,      32'h3044, 1'b1, 1'b1, 1'b0, 32'd1);
    add(1'b0, 1'b1, 3'b011, 26'h0,        1'b0, 32'h3100,   32'h3044, 1'b1, 1'b1, 1'b0, 32'd1);
    add(1'b1, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3000, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b011, 26'h0,        1'b0, 32'h6FFC,   32'h6FFC, 1'b0, 1'b0, 1'b0, 32'd1);
    add(1'b0, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h6FFC, 1'b1, 1'b1, 1'b0, 32'd1);
    add(1'b1, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3000, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 3'b011, 26'h0,        1'b0, 32'h2FFC,   32'h3000, 1'b1, 1'b1, 1'b0, 32'd0);
    add(1'b1, 1'b0, 3'b000, 26'h0,        1'b0, 32'h0,      32'h3000, 1'b0, 1'b0, 1'b0, 32'd0);
    foreach (vecs[i]) step(vecs[i], i);

    // illegal_op is a single-cycle pulse per illegal select, even back to back with a gap
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; npc_op = 3'b101;
    @(posedge clk); #1;
    chk("seq ill first", {31'b0, illegal_op}, 32'd1);
    chk("seq ill pc", pc, 32'h3004);
    @(negedge clk);
    npc_op = 3'b000;
    @(posedge clk); #1;
    chk("seq ill cleared", {31'b0, illegal_op}, 32'd0);
    @(negedge clk);
    npc_op = 3'b110;
    @(posedge clk); #1;
    chk("seq ill again", {31'b0, illegal_op}, 32'd1);
    chk("seq ill cnt", redirect_cnt, 32'd0);

    // long stall: nothing moves across many edges, then the held op commits
    @(negedge clk);
    stall = 1'b1; npc_op = 3'b001; imm26 = 26'h0000C40;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d pc", k), pc, 32'h300C);
      chk($sformatf("stall%0d cnt", k), redirect_cnt, 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("post stall pc", pc, 32'h3100);
    chk("post stall cnt", redirect_cnt, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
